ste_led_bar_pk: RTL and testbench

STE_LED_BAR_PK -- requirements
Module: ste_led_bar_pk

---
 rtl/ste_led_bar_pk.sv | 180 ++++++++++++++++++
 tb/tb_ste_led_bar_pk.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ste_led_bar_pk.sv
// LED bar/dot level meter with optional peak-hold marker (build macro STE_LED_BAR_PEAK_EN).
// Latency: 1 cycle from din_update_i strobe to led_o; mode_i acts combinationally.
// Backpressure: none; every strobe is accepted, and clr_i wins over a simultaneous strobe.
module ste_led_bar_pk #(
    parameter int                DATA_W    = 4,
    parameter logic [DATA_W-1:0] DATA_MAX  = 4'hF,
    parameter int                LED_NR    = 8,
    parameter int                HOLD_CYC  = 50_000_000,
    parameter int                DECAY_CYC = 5_000_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_W-1:0]            din_i,
    input  logic                         din_update_i,
    input  logic                         clr_i,
    input  logic                         mode_i,
    output logic [LED_NR-1:0]            led_o,
    output logic [$clog2(LED_NR+1)-1:0]  peak_o
);

    localparam int LW = $clog2(LED_NR + 1);
    // Wide enough for din*LED_NR and k*DATA_MAX with LED_NR up to 32.
    localparam int MW = DATA_W + 6;

    // Reject parameter values the arithmetic and counters are not built for.
    if (DATA_W < 2 || DATA_W > 16) begin : g_bad_data_w
        $error("DATA_W out of range");
    end
    if (DATA_MAX == '0) begin : g_bad_data_max
        $error("DATA_MAX must be nonzero");
    end
    if (LED_NR < 2 || LED_NR > 32) begin : g_bad_led_nr
        $error("LED_NR out of range");
    end
    if (HOLD_CYC < 1 || DECAY_CYC < 1) begin : g_bad_cyc
        $error("HOLD_CYC and DECAY_CYC must be at least 1");
    end

    logic [MW-1:0] w_prod;
    logic [LW-1:0] w_new_lvl;
    logic [LW-1:0] r_level;
    logic [LW-1:0] w_peak_disp;

    // Quantise the input: highest k with din*LED_NR >= k*DATA_MAX (saturates naturally).
    always_comb begin
        w_prod    = MW'(din_i) * MW'(LED_NR);
        w_new_lvl = '0;
        for (int k = 1; k <= LED_NR; k++) begin
            if (w_prod >= MW'(k) * MW'(DATA_MAX)) begin
                w_new_lvl = LW'(k);
            end
        end
    end

    // Level register: loads on strobe only, cleared by clr_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else if (clr_i) begin
            r_level <= '0;
        end else if (din_update_i) begin
            r_level <= w_new_lvl;
        end
    end

`ifdef STE_LED_BAR_PEAK_EN
    localparam int HW = (HOLD_CYC  > 1) ? $clog2(HOLD_CYC)  : 1;
    localparam int DW = (DECAY_CYC > 1) ? $clog2(DECAY_CYC) : 1;
    localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD_CYC - 1);
    localparam logic [DW-1:0] DECAY_LD = DW'(DECAY_CYC - 1);

    typedef enum logic [1:0] {
        ST_TRACK = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DECAY = 2'd2
    } state_t;

    state_t        r_state, w_state_nx;
    logic [LW-1:0] r_peak,  w_peak_nx;
    logic [HW-1:0] r_hold,  w_hold_nx;
    logic [DW-1:0] r_decay, w_decay_nx;
    logic [LW-1:0] w_cmp_lvl;

    // Peak state and counters register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_TRACK;
            r_peak  <= '0;
            r_hold  <= '0;
            r_decay <= '0;
        end else begin
            r_state <= w_state_nx;
            r_peak  <= w_peak_nx;
            r_hold  <= w_hold_nx;
            r_decay <= w_decay_nx;
        end
    end

    // Peak next-state: clear, then capture/rearm on strobe, else hold/decay countdown.
    always_comb begin
        w_state_nx = r_state;
        w_peak_nx  = r_peak;
        w_hold_nx  = r_hold;
        w_decay_nx = r_decay;
        // A strobe that does not capture still moves the level the peak is compared to.
        w_cmp_lvl  = din_update_i ? w_new_lvl : r_level;
        if (clr_i) begin
            w_state_nx = ST_TRACK;
            w_peak_nx  = '0;
            w_hold_nx  = '0;
            w_decay_nx = '0;
        end else if (din_update_i && (w_new_lvl >= r_peak || r_state == ST_TRACK)) begin
            if (w_new_lvl >= r_peak) begin
                w_peak_nx = w_new_lvl;
            end
            w_state_nx = ST_HOLD;
            w_hold_nx  = HOLD_LD;
            w_decay_nx = '0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_hold == '0) begin
                        if (r_peak > w_cmp_lvl) begin
                            w_state_nx = ST_DECAY;
                            w_decay_nx = DECAY_LD;
                        end else begin
                            w_state_nx = ST_TRACK;
                            w_peak_nx  = w_cmp_lvl;
                        end
                    end else begin
                        w_hold_nx = r_hold - 1'b1;
                    end
                end
                ST_DECAY: begin
                    if (r_decay == '0) begin
                        // Peak is above level here, so peak-1 cannot underflow.
                        if (r_peak - 1'b1 <= w_cmp_lvl) begin
                            w_state_nx = ST_TRACK;
                            w_peak_nx  = w_cmp_lvl;
                            w_decay_nx = '0;
                        end else begin
                            w_peak_nx  = r_peak - 1'b1;
                            w_decay_nx = DECAY_LD;
                        end
                    end else begin
                        w_decay_nx = r_decay - 1'b1;
                    end
                end
                default: begin
                    w_state_nx = ST_TRACK;
                end
            endcase
        end
    end

    assign w_peak_disp = r_peak;
`else
    assign w_peak_disp = '0;
`endif

    assign peak_o = w_peak_disp;

    // LED decode: bar or dot for the level, plus the peak marker when nonzero.
    always_comb begin
        led_o = '0;
        for (int i = 0; i < LED_NR; i++) begin
            if (mode_i) begin
                if (LW'(i + 1) == r_level) begin
                    led_o[i] = 1'b1;
                end
            end else if (LW'(i) < r_level) begin
                led_o[i] = 1'b1;
            end
            if (LW'(i + 1) == w_peak_disp) begin
                led_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ste_led_bar_pk.sv
// Directed bench for ste_led_bar_pk with HOLD_CYC=4, DECAY_CYC=2, 8 LEDs, DATA_MAX=15.
// Expectations follow the peak-enabled build when STE_LED_BAR_PEAK_EN is defined,
// otherwise the level-only build.
module tb_ste_led_bar_pk;

`ifdef STE_LED_BAR_PEAK_EN
    localparam bit PK = 1'b1;
`else
    localparam bit PK = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] din_i;
    logic       din_update_i;
    logic       clr_i;
    logic       mode_i;
    logic [7:0] led_o;
    logic [3:0] peak_o;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    ste_led_bar_pk #(
        .DATA_W    (4),
        .DATA_MAX  (4'hF),
        .LED_NR    (8),
        .HOLD_CYC  (4),
        .DECAY_CYC (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din_i        (din_i),
        .din_update_i (din_update_i),
        .clr_i        (clr_i),
        .mode_i       (mode_i),
        .led_o        (led_o),
        .peak_o       (peak_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Apply inputs for one clock edge, then sample 1 time unit after the edge.
    task automatic step(input logic upd, input logic [3:0] d, input logic clr);
        din_update_i = upd;
        din_i        = d;
        clr_i        = clr;
        @(posedge clk);
        #1;
        din_update_i = 1'b0;
        clr_i        = 1'b0;
    endtask

    int exp_pk [10] = '{8, 8, 8, 7, 7, 6, 6, 5, 5, 4};
    logic [7:0] one8;
    logic [7:0] exp_led;

    initial begin
        rst_n        = 1'b0;
        din_i        = '0;
        din_update_i = 1'b0;
        clr_i        = 1'b0;
        mode_i       = 1'b0;
        one8         = 8'h01;

        // Reset state, while asserted and after release.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_led", led_o, 8'h00);
        chk("rst_peak", peak_o, 4'd0);
        rst_n = 1'b1;
        step(1'b0, 4'd0, 1'b0);
        chk("post_rst_led", led_o, 8'h00);
        chk("post_rst_peak", peak_o, 4'd0);

        // Full scale, then a lower level while the peak is held.
        step(1'b1, 4'd15, 1'b0);
        chk("full_led", led_o, 8'hFF);
        chk("full_peak", peak_o, PK ? 4'd8 : 4'd0);
        step(1'b0, 4'd0, 1'b0);
        chk("full_hold_led", led_o, 8'hFF);
        step(1'b1, 4'd8, 1'b0);
        chk("half_led", led_o, PK ? 8'h8F : 8'h0F);
        chk("half_peak", peak_o, PK ? 4'd8 : 4'd0);
        mode_i = 1'b1;
        #1;
        chk("dot_led", led_o, PK ? 8'h88 : 8'h08);
        mode_i = 1'b0;
        #1;

        // Hold then one-LED decay every two cycles down to the level.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'd0, 1'b0);
            exp_led = PK ? (8'h0F | (one8 << (exp_pk[i] - 1))) : 8'h0F;
            chk($sformatf("decay_peak_%0d", i), peak_o, PK ? 4'(exp_pk[i]) : 4'd0);
            chk($sformatf("decay_led_%0d", i), led_o, exp_led);
        end
        repeat (3) step(1'b0, 4'd0, 1'b0);
        chk("track_peak", peak_o, PK ? 4'd4 : 4'd0);
        chk("track_led", led_o, 8'h0F);

        // Quantisation boundaries: 1 -> level 0, 2 -> 1, 7 -> 3, 14 -> 7.
        step(1'b1, 4'd1, 1'b0);
        chk("din1_led", led_o, PK ? 8'h08 : 8'h00);
        chk("din1_peak", peak_o, PK ? 4'd4 : 4'd0);
        mode_i = 1'b1;
        #1;
        chk("din1_dot_led", led_o, PK ? 8'h08 : 8'h00);
        mode_i = 1'b0;
        #1;
        step(1'b1, 4'd2, 1'b0);
        chk("din2_led", led_o, PK ? 8'h09 : 8'h01);
        step(1'b1, 4'd7, 1'b0);
        chk("din7_led", led_o, PK ? 8'h0F : 8'h07);
        step(1'b1, 4'd14, 1'b0);
        chk("din14_led", led_o, 8'h7F);
        chk("din14_peak", peak_o, PK ? 4'd7 : 4'd0);

        // Clear alone, then clear winning over a simultaneous strobe.
        step(1'b0, 4'd0, 1'b1);
        chk("clr_led", led_o, 8'h00);
        chk("clr_peak", peak_o, 4'd0);
        mode_i = 1'b1;
        #1;
        chk("clr_dot_led", led_o, 8'h00);
        mode_i = 1'b0;
        #1;
        step(1'b1, 4'd15, 1'b1);
        chk("clrupd_led", led_o, 8'h00);
        chk("clrupd_peak", peak_o, 4'd0);
        step(1'b0, 4'd0, 1'b0);
        chk("clrupd_idle_led", led_o, 8'h00);
        chk("clrupd_idle_peak", peak_o, 4'd0);
        step(1'b1, 4'd8, 1'b0);
        chk("after_clr_led", led_o, 8'h0F);
        chk("after_clr_peak", peak_o, PK ? 4'd4 : 4'd0);

        // Asynchronous reset in the middle of decay.
        step(1'b1, 4'd15, 1'b0);
        step(1'b1, 4'd8, 1'b0);
        repeat (3) step(1'b0, 4'd0, 1'b0);
        chk("pre_rst_led", led_o, PK ? 8'h8F : 8'h0F);
        chk("pre_rst_peak", peak_o, PK ? 4'd8 : 4'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_led", led_o, 8'h00);
        chk("async_rst_peak", peak_o, 4'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 4'd8, 1'b0);
        chk("rerun_led", led_o, 8'h0F);
        chk("rerun_peak", peak_o, PK ? 4'd4 : 4'd0);
        step(1'b0, 4'd0, 1'b0);
        chk("rerun_hold_led", led_o, 8'h0F);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
